// File: rtl/bcd2angle_conv_if.sv
// Request/result bundle between the decimal command parser and the angle converter.
//
// Handshake: the master raises i_start with i_bcd/i_frccnt valid; the converter
// accepts it on a rising edge only while idle and not showing a result (o_busy=0,
// o_valid=0). Acceptance is visible as o_busy=1 on the next cycle. Requests while
// busy or during the o_valid cycle are dropped, never queued. The result is
// announced by a single-cycle o_valid pulse; o_angle/o_err hold until the next one.
interface bcd2angle_conv_if #(
  parameter int NDIG  = 16,
  parameter int OUT_W = 14
);
  localparam int FW = $clog2(NDIG + 1);

  logic                i_start;
  logic [4*NDIG-1:0]   i_bcd;
  logic [FW-1:0]       i_frccnt;
  logic                o_busy;
  logic                o_valid;
  logic [OUT_W-1:0]    o_angle;
  logic                o_err;
  logic [2:0]          o_dbg_state;

  modport master (
    output i_start, i_bcd, i_frccnt,
    input  o_busy, o_valid, o_angle, o_err, o_dbg_state
  );

  modport slave (
    input  i_start, i_bcd, i_frccnt,
    output o_busy, o_valid, o_angle, o_err, o_dbg_state
  );
endinterface

// File: rtl/bcd2angle_conv.sv
// Fixed-point BCD degrees -> binary fraction of a full turn.
// o_angle = floor((N mod D) * 2^OUT_W / D), N = decimal value of the digits,
// D = 360 * 10^frccnt. Exact: digits accumulate into binary, then a restoring
// modulo pass wraps to one turn and a restoring divide produces the fraction.
module bcd2angle_conv #(
  parameter int NDIG  = 16,
  parameter int OUT_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst,
  bcd2angle_conv_if.slave   bus
);
  localparam int FW   = $clog2(NDIG + 1);
  localparam int NW   = 4 * NDIG;
  localparam int DW   = 4 * NDIG + 10;
  localparam int MAXC = (NW > OUT_W) ? NW : OUT_W;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MOD  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [NW-1:0]     bcd_q;
  logic [FW-1:0]     frc_q;
  logic [NW-1:0]     n;
  logic [DW-1:0]     d;
  logic [DW-1:0]     r;
  logic [OUT_W-1:0]  q;
  logic [CW-1:0]     cnt;
  logic              err;
  logic              busy_q;
  logic              valid_q;
  logic [OUT_W-1:0]  angle_q;
  logic              err_q;

  logic              accept;
  logic              bad_digit;
  logic              load_last, mod_last, div_last;
  logic [3:0]        digit;
  logic [DW-1:0]     mod_sh, div_sh;

  assign bus.o_busy      = busy_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_angle     = angle_q;
  assign bus.o_err       = err_q;
  assign bus.o_dbg_state = state;

  // A request that arrives while the previous result is being shown is dropped.
  assign accept    = (state == S_IDLE) && bus.i_start && !valid_q;
  assign load_last = (cnt == CW'(NDIG - 1));
  assign mod_last  = (cnt == CW'(NW - 1));
  assign div_last  = (cnt == CW'(OUT_W - 1));
  assign digit     = bcd_q[NW-1 -: 4];
  // r stays below d, so one extra bit of shift headroom always fits in DW.
  assign mod_sh    = {r[DW-2:0], n[NW-1]};
  assign div_sh    = {r[DW-2:0], 1'b0};

  // Input validation: any non-decimal nibble flags the request as bad.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (bus.i_bcd[4*k +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state: fixed-length phases, so latency never depends on the data.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept)    state_n = S_LOAD;
      S_LOAD:  if (load_last) state_n = S_MOD;
      S_MOD:   if (mod_last)  state_n = S_DIV;
      S_DIV:   if (div_last)  state_n = S_DONE;
      S_DONE:                 state_n = S_IDLE;
      default:                state_n = S_IDLE;
    endcase
  end

  // Datapath and registered outputs, advanced one step per cycle by phase.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bcd_q   <= '0;
      frc_q   <= '0;
      n       <= '0;
      d       <= '0;
      r       <= '0;
      q       <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      angle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_q <= 1'b0;
          busy_q  <= accept;
          if (accept) begin
            bcd_q <= bus.i_bcd;
            frc_q <= bus.i_frccnt;
            n     <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            d     <= DW'(360);
            err   <= bad_digit || (int'(bus.i_frccnt) > NDIG);
          end
        end
        S_LOAD: begin
          // n*10 + digit without a multiplier; MSD first.
          n     <= (n << 3) + (n << 1) + NW'(digit);
          bcd_q <= bcd_q << 4;
          if (int'(cnt) < int'(frc_q)) d <= (d << 3) + (d << 1);
          cnt   <= load_last ? '0 : cnt + 1'b1;
        end
        S_MOD: begin
          // Restoring remainder of n by d: wraps the angle into one turn.
          r   <= (mod_sh >= d) ? (mod_sh - d) : mod_sh;
          n   <= n << 1;
          cnt <= mod_last ? '0 : cnt + 1'b1;
        end
        S_DIV: begin
          // Restoring fractional divide: one quotient bit per cycle, MSB first.
          r   <= (div_sh >= d) ? (div_sh - d) : div_sh;
          q   <= (q << 1) | OUT_W'(div_sh >= d);
          cnt <= div_last ? '0 : cnt + 1'b1;
        end
        S_DONE: begin
          angle_q <= err ? '0 : q;
          err_q   <= err;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd2angle_conv.sv
// Directed test of bcd2angle_conv (NDIG=16, OUT_W=14) with hand-computed angles.
module tb_bcd2angle_conv;
  localparam int NDIG  = 16;
  localparam int OUT_W = 14;
  localparam int LAT   = 95;

  logic clk;
  logic rst;
  int   cyc;
  int   t0;
  int   n_checks;
  int   n_errs;

  bcd2angle_conv_if #(.NDIG(NDIG), .OUT_W(OUT_W)) bus ();

  bcd2angle_conv #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle request; returns just after the sampling edge.
  task automatic start_req(input logic [63:0] bcd, input logic [4:0] frc);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_bcd    = bcd;
    bus.i_frccnt = frc;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.i_start  = 1'b0;
    bus.i_bcd    = 64'h1234_5678_9999_0000;
    bus.i_frccnt = 5'd3;
  endtask

  // Wait (bounded) for o_valid; latency counted in edges since acceptance.
  task automatic wait_valid(output int lat);
    while (!bus.o_valid && (cyc - t0) < 300) begin
      @(posedge clk);
      #1;
    end
    lat = cyc - t0;
  endtask

  task automatic watch_no_valid(input int ncyc, output int nvalid);
    nvalid = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) nvalid++;
    end
  endtask

  task automatic run_case(input string tag, input logic [63:0] bcd, input logic [4:0] frc,
                          input int exp_angle, input logic exp_err);
    int lat;
    start_req(bcd, frc);
    check_val({tag, "_busy"}, bus.o_busy, 1);
    wait_valid(lat);
    check_val({tag, "_lat"}, lat, LAT);
    check_val({tag, "_angle"}, bus.o_angle, exp_angle);
    check_val({tag, "_err"}, bus.o_err, exp_err);
    @(posedge clk);
    #1;
    check_val({tag, "_pulse"}, bus.o_valid, 0);
    check_val({tag, "_idle"}, bus.o_busy, 0);
  endtask

  initial begin
    int lat;
    int nv;
    n_checks = 0;
    n_errs   = 0;
    rst          = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_bcd    = '0;
    bus.i_frccnt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", bus.o_busy, 0);
    check_val("rst_valid", bus.o_valid, 0);
    check_val("rst_angle", bus.o_angle, 0);
    check_val("rst_err", bus.o_err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Main function: quarter turn, near-full turn, eighth turn, half turn.
    run_case("deg90_0",   64'h0000_0000_0000_0900, 5'd1, 4096, 1'b0);
    run_case("deg359_99", 64'h0000_0000_0003_5999, 5'd2, 16383, 1'b0);
    run_case("deg45",     64'h0000_0000_0000_0045, 5'd0, 2048, 1'b0);
    run_case("deg180",    64'h0000_0000_0000_0180, 5'd0, 8192, 1'b0);
    // Wrap and boundaries.
    run_case("deg720_5",  64'h0000_0000_0000_7205, 5'd1, 22, 1'b0);
    run_case("deg360",    64'h0000_0000_0000_0360, 5'd0, 0, 1'b0);
    run_case("zero",      64'h0000_0000_0000_0000, 5'd4, 0, 1'b0);
    run_case("pure_frac", 64'h9999_9999_9999_9999, 5'd16, 45, 1'b0);
    // Errors keep the same latency and force angle 0.
    run_case("bad_digit", 64'h0000_0000_0000_00A5, 5'd0, 0, 1'b1);
    run_case("bad_frc",   64'h0000_0000_0000_0900, 5'd17, 0, 1'b1);
    run_case("recover",   64'h0000_0000_0000_0045, 5'd0, 2048, 1'b0);

    // Second start while busy is ignored.
    start_req(64'h0000_0000_0000_0900, 5'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_bcd    = 64'h0000_0000_0000_0180;
    bus.i_frccnt = 5'd0;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_valid(lat);
    check_val("busy_start_lat", lat, LAT);
    check_val("busy_start_angle", bus.o_angle, 4096);
    watch_no_valid(120, nv);
    check_val("busy_start_extra_valid", nv, 0);

    // Start during the o_valid cycle is ignored.
    start_req(64'h0000_0000_0000_0045, 5'd0);
    wait_valid(lat);
    check_val("vcyc_lat", lat, LAT);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_bcd    = 64'h0000_0000_0000_0900;
    bus.i_frccnt = 5'd1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check_val("vcyc_busy", bus.o_busy, 0);
    check_val("vcyc_state", bus.o_dbg_state, 0);
    watch_no_valid(120, nv);
    check_val("vcyc_extra_valid", nv, 0);
    check_val("vcyc_angle_held", bus.o_angle, 2048);

    // Reset mid-operation aborts with no result.
    start_req(64'h0000_0000_0000_0180, 5'd0);
    repeat (39) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_busy", bus.o_busy, 0);
    check_val("abort_valid", bus.o_valid, 0);
    check_val("abort_angle", bus.o_angle, 0);
    check_val("abort_state", bus.o_dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    watch_no_valid(120, nv);
    check_val("abort_no_valid", nv, 0);
    run_case("after_abort", 64'h0000_0000_0000_0900, 5'd1, 4096, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
